// File: rtl/muldiv_arb.sv
// muldiv_arb: round-robin issue arbiter and launch sequencer for the shared MUL/DIV unit.
// Optional MULDIV_BYPASS_EN lets a grant skip the empty FIFO straight into the launch registers.
module muldiv_arb #(
    parameter int LANES = 4,
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [LANES-1:0]        req_vld,
    input  logic [LANES*XLEN-1:0]   req_instr,
    input  logic [LANES*XLEN-1:0]   req_rs0,
    input  logic [LANES*XLEN-1:0]   req_rs1,
    output logic [LANES-1:0]        req_gnt,
    output logic                    md_vld,
    output logic [XLEN-1:0]         md_instr,
    output logic [XLEN-1:0]         md_rs0,
    output logic [XLEN-1:0]         md_rs1,
    input  logic                    md_busy,
    output logic                    arb_full,
    output logic [$clog2(DEPTH+1)-1:0] q_cnt
);
    localparam int PW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [PW-1:0]     r_rr, w_sel, w_idx;
    logic [AW-1:0]     r_wr, r_rd;
    logic [CW-1:0]     r_cnt;
    logic [3*XLEN-1:0] r_mem [DEPTH];
    logic [3*XLEN-1:0] r_md, w_new;
    logic              r_md_vld, w_any, w_grant, w_launch_ok, w_empty, w_pop, w_push, w_bypass;
    // Scan from the lowest priority lane upward so the last hit is the winner.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            w_idx = PW'((int'(r_rr) + k) % LANES);
            if (req_vld[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end
    assign arb_full    = r_cnt == CW'(DEPTH);
    assign w_grant     = w_any & ~flush & ~arb_full;
    assign req_gnt     = w_grant ? LANES'(1) << w_sel : '0;
    assign w_new       = {req_instr[w_sel*XLEN +: XLEN], req_rs0[w_sel*XLEN +: XLEN], req_rs1[w_sel*XLEN +: XLEN]};
    assign w_launch_ok = ~md_busy & ~r_md_vld & ~flush;
    assign w_empty     = r_cnt == '0;
    assign w_pop       = w_launch_ok & ~w_empty;
`ifdef MULDIV_BYPASS_EN
    assign w_bypass    = w_grant & w_empty & w_launch_ok;
`else
    assign w_bypass    = 1'b0;
`endif
    assign w_push      = w_grant & ~w_bypass;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr     <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_md_vld <= 1'b0;
            r_md     <= '0;
        end else begin
            if (w_grant) r_rr <= (w_sel == PW'(LANES-1)) ? '0 : w_sel + 1'b1;
            r_md_vld <= w_pop | w_bypass;
            if (w_pop) r_md <= r_mem[r_rd];
            else if (w_bypass) r_md <= w_new;
            if (flush) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                r_wr  <= r_wr + AW'(w_push);
                r_rd  <= r_rd + AW'(w_pop);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_new;
    end
    assign md_vld = r_md_vld;
    assign {md_instr, md_rs0, md_rs1} = r_md;
    assign q_cnt = r_cnt;
endmodule

// File: tb/tb_muldiv_arb.sv
// tb_muldiv_arb: randomized and directed checks of muldiv_arb against a queue-based reference model.
module tb_muldiv_arb;
    localparam int LANES = 4;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
`ifdef MULDIV_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed { logic [XLEN-1:0] i, a, b; } ent_t;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, md_busy = 1'b0;
    logic [LANES-1:0] req_vld = '0, req_gnt;
    logic [LANES*XLEN-1:0] req_instr = '0, req_rs0 = '0, req_rs1 = '0;
    logic md_vld, arb_full;
    logic [XLEN-1:0] md_instr, md_rs0, md_rs1;
    logic [$clog2(DEPTH+1)-1:0] q_cnt;
    int n_chk = 0, n_err = 0;
    ent_t q[$];
    ent_t m_cur = '0;
    bit m_vld = 1'b0;
    int rr = 0;

    muldiv_arb #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_vld(req_vld),
        .req_instr(req_instr), .req_rs0(req_rs0), .req_rs1(req_rs1),
        .req_gnt(req_gnt), .md_vld(md_vld), .md_instr(md_instr),
        .md_rs0(md_rs0), .md_rs1(md_rs1), .md_busy(md_busy),
        .arb_full(arb_full), .q_cnt(q_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input logic [LANES-1:0] eg);
        chk("gnt", 32'(req_gnt), 32'(eg));
        chk("full", 32'(arb_full), 32'(q.size() == DEPTH));
        chk("cnt", 32'(q_cnt), 32'(q.size()));
        chk("vld", 32'(md_vld), 32'(m_vld));
        chk("instr", md_instr, m_cur.i);
        chk("rs0", md_rs0, m_cur.a);
        chk("rs1", md_rs1, m_cur.b);
    endtask

    // One cycle: drive at the falling edge, compare, then advance the model to the next rising edge.
    task automatic step(input logic [LANES-1:0] v, input logic b, input logic f);
        logic [LANES-1:0] eg;
        int gl;
        bit lo, nv, byp;
        ent_t e;
        @(negedge clk);
        req_vld = v;
        md_busy = b;
        flush = f;
        for (int l = 0; l < LANES; l++) begin
            req_instr[l*XLEN +: XLEN] = $urandom;
            req_rs0[l*XLEN +: XLEN] = $urandom;
            req_rs1[l*XLEN +: XLEN] = $urandom;
        end
        #1;
        eg = '0;
        gl = -1;
        if (!f && q.size() < DEPTH)
            for (int k = 0; k < LANES; k++)
                if (gl < 0 && v[(rr + k) % LANES]) gl = (rr + k) % LANES;
        if (gl >= 0) eg[gl] = 1'b1;
        check_outputs(eg);
        if (gl >= 0) e = '{req_instr[gl*XLEN +: XLEN], req_rs0[gl*XLEN +: XLEN], req_rs1[gl*XLEN +: XLEN]};
        lo = !b && !m_vld && !f;
        nv = 1'b0;
        byp = 1'b0;
        if (lo && q.size() > 0) begin
            m_cur = q.pop_front();
            nv = 1'b1;
        end else if (lo && gl >= 0 && BYP) begin
            m_cur = e;
            nv = 1'b1;
            byp = 1'b1;
        end
        if (gl >= 0 && !byp) q.push_back(e);
        if (f) q.delete();
        if (gl >= 0) rr = (gl + 1) % LANES;
        m_vld = nv;
    endtask

    task automatic model_reset();
        q.delete();
        m_cur = '0;
        m_vld = 1'b0;
        rr = 0;
    endtask

    initial begin
        #2;
        check_outputs('0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) step(4'hF, 1'b0, 1'b0);
        repeat (4) step(4'h0, 1'b0, 1'b0);
        step(4'h1, 1'b1, 1'b0);
        step(4'h2, 1'b1, 1'b0);
        step(4'h4, 1'b1, 1'b0);
        repeat (5) step(4'h0, 1'b0, 1'b0);
        step(4'h1, 1'b1, 1'b0);
        step(4'h1, 1'b1, 1'b0);
        step(4'h2, 1'b1, 1'b1);
        repeat (4) step(4'h0, 1'b0, 1'b0);
        step(4'h3, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        repeat (33) step(4'h0, 1'b1, 1'b0);
        repeat (4) step(4'h0, 1'b0, 1'b0);
        step(4'h1, 1'b1, 1'b0);
        step(4'h2, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        @(negedge clk);
        req_vld = '0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs('0);
        @(negedge clk);
        rst = 1'b0;
        step(4'h1, 1'b0, 1'b0);
        repeat (4000) step(4'($urandom), $urandom_range(0, 1) == 0, $urandom_range(0, 19) == 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
